descrambler_multilane: RTL and testbench

DESCRAMBLER_MULTILANE -- requirements
Module: descrambler_multilane

---
 rtl/descrambler_pkg.sv | 42 ++++
 rtl/descrambler_lane.sv | 71 +++++++
 rtl/descrambler_multilane.sv | 44 ++++
 tb/tb_descrambler_multilane.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/descrambler_pkg.sv
// descrambler_pkg: shared constants, lane FSM states and the 8-bit LFSR step for the multilane descrambler
package descrambler_pkg;
   // Galois feedback masks; the x^N term is implied by the width mask
   localparam logic [22:0] G12_TAPS = 23'h000039;
   localparam logic [22:0] G12_MASK = 23'h00FFFF;
   localparam logic [22:0] G3_TAPS  = 23'h210125;
   localparam logic [22:0] G3_MASK  = 23'h7FFFFF;
   localparam logic [15:0] G12_INIT = 16'hFFFF;
   localparam logic [7:0]  K_COM    = 8'hBC;
   localparam logic [7:0]  K_SKP    = 8'h1C;
   localparam logic [7:0]  OS_SKP   = 8'hAA;
   localparam logic [7:0]  OS_EIEOS = 8'h00;
   localparam logic [1:0]  SH_DATA  = 2'b01;
   localparam logic [1:0]  SH_OS    = 2'b10;

   typedef enum logic [2:0] {IDLE, DATA_BLK, OS_BLK, SKP_BLK, EIEOS_BLK} lane_state_e;

   typedef struct packed {
      logic [7:0]  key;
      logic [22:0] state;
   } lfsr_step_t;

   // Runs the LFSR 8 bit-times; key bit i is the MSB seen at step i
   function automatic lfsr_step_t lfsr_adv8(input logic [22:0] s, input logic [22:0] taps,
                                            input logic [22:0] mask);
      lfsr_step_t r;
      logic fb;
      r.key = '0;
      r.state = s;
      for (int i = 0; i < 8; i++) begin
         fb = |(r.state & mask & ~(mask >> 1));
         r.key[i] = fb;
         r.state = ((r.state << 1) & mask) ^ ({23{fb}} & taps);
      end
      return r;
   endfunction

   function automatic lane_state_e block_kind(input logic [1:0] hdr, input logic [7:0] sym0);
      return hdr == SH_DATA ? DATA_BLK : hdr != SH_OS ? IDLE :
             sym0 == OS_SKP ? SKP_BLK : sym0 == OS_EIEOS ? EIEOS_BLK : OS_BLK;
   endfunction
endpackage

// File: rtl/descrambler_lane.sv
// descrambler_lane: one lane of descrambling, Gen1/2 16-bit and Gen3 23-bit LFSRs with block FSM
// Ports: RX_CLK/rst (async active-low), gen3_mode, descramble_en, lfsr_reload, seed[23:0],
//        in_valid/in_data/in_dk/in_sync_header/in_block_start -> out_valid/out_data/out_dk (1 clock later)
module descrambler_lane
   import descrambler_pkg::*;
(
   input  logic        RX_CLK,
   input  logic        rst,
   input  logic        gen3_mode,
   input  logic        descramble_en,
   input  logic        lfsr_reload,
   input  logic [23:0] seed,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_dk,
   input  logic [1:0]  in_sync_header,
   input  logic        in_block_start,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_dk
);
   logic [15:0] lfsr12, cur12, nxt12;
   logic [22:0] lfsr3, cur3, nxt3;
   lane_state_e state, cur_state, eff_state;
   logic [3:0]  cnt, cur_cnt, sym_idx;
   lfsr_step_t  st12, st3;
   logic [7:0]  d12, d3;
   logic        is_com, is_skp, desc3, adv3, unused_bits;

   assign unused_bits = ^{seed[23], st12.state[22:16]};

   // Reload overrides the stored state so a symbol arriving with it sees the initial values
   always_comb begin
      cur12     = lfsr_reload ? G12_INIT : lfsr12;
      cur3      = lfsr_reload ? seed[22:0] : lfsr3;
      cur_state = lfsr_reload ? IDLE : state;
      cur_cnt   = lfsr_reload ? 4'd0 : cnt;
      st12      = lfsr_adv8({7'd0, cur12}, G12_TAPS, G12_MASK);
      st3       = lfsr_adv8(cur3, G3_TAPS, G3_MASK);
      is_com    = in_dk && in_data == K_COM;
      is_skp    = in_dk && in_data == K_SKP;
      d12       = in_dk || !descramble_en ? in_data : in_data ^ st12.key;
      nxt12     = is_com ? G12_INIT : is_skp ? cur12 : st12.state[15:0];
      eff_state = in_block_start ? block_kind(in_sync_header, in_data) : cur_state;
      sym_idx   = in_block_start ? 4'd0 : cur_cnt;
      desc3     = eff_state == DATA_BLK || (eff_state == OS_BLK && sym_idx != 4'd0);
      adv3      = eff_state == DATA_BLK || eff_state == OS_BLK || eff_state == EIEOS_BLK;
      d3        = desc3 && descramble_en ? in_data ^ st3.key : in_data;
      nxt3      = eff_state == EIEOS_BLK && sym_idx == 4'hF ? seed[22:0] : adv3 ? st3.state : cur3;
   end

   always_ff @(posedge RX_CLK or negedge rst) begin
      if (!rst) begin
         lfsr12    <= G12_INIT;
         lfsr3     <= seed[22:0];
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_dk    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         out_dk    <= in_dk;
         out_data  <= in_valid ? (gen3_mode ? d3 : d12) : out_data;
         lfsr12    <= in_valid && !gen3_mode ? nxt12 : cur12;
         lfsr3     <= in_valid && gen3_mode ? nxt3 : cur3;
         state     <= in_valid && gen3_mode ? eff_state : cur_state;
         cnt       <= in_valid && gen3_mode ? sym_idx + 4'd1 : cur_cnt;
      end
   end
endmodule

// File: rtl/descrambler_multilane.sv
// descrambler_multilane: LANES independent PCIe descrambler lanes with 1-clock latency
// Ports: RX_CLK/rst (async active-low), gen3_mode, descramble_en, lfsr_reload, seed (24 bits/lane),
//        per-lane in_valid/in_data/in_dk/in_sync_header/in_block_start -> out_valid/out_data/out_dk
module descrambler_multilane
   import descrambler_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int SEED_WIDTH = 24
) (
   input  logic                        RX_CLK,
   input  logic                        rst,
   input  logic                        gen3_mode,
   input  logic                        descramble_en,
   input  logic                        lfsr_reload,
   input  logic [LANES*SEED_WIDTH-1:0] seed,
   input  logic [LANES-1:0]            in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic [LANES-1:0]            in_dk,
   input  logic [LANES*2-1:0]          in_sync_header,
   input  logic [LANES-1:0]            in_block_start,
   output logic [LANES-1:0]            out_valid,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_dk
);
   for (genvar i = 0; i < LANES; i++) begin : gen_lane
      descrambler_lane u_lane (
         .RX_CLK         (RX_CLK),
         .rst            (rst),
         .gen3_mode      (gen3_mode),
         .descramble_en  (descramble_en),
         .lfsr_reload    (lfsr_reload),
         .seed           (seed[i*SEED_WIDTH +: 24]),
         .in_valid       (in_valid[i]),
         .in_data        (in_data[i*DATA_WIDTH +: 8]),
         .in_dk          (in_dk[i]),
         .in_sync_header (in_sync_header[i*2 +: 2]),
         .in_block_start (in_block_start[i]),
         .out_valid      (out_valid[i]),
         .out_data       (out_data[i*DATA_WIDTH +: 8]),
         .out_dk         (out_dk[i])
      );
   end
endmodule

// File: tb/tb_descrambler_multilane.sv
// tb_descrambler_multilane: directed self-checking bench for descrambler_multilane
module tb_descrambler_multilane;
   localparam int L = 4;
   localparam logic [22:0] SEED0 = 23'h1DBFBC;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           gen3_mode = 1'b0;
   logic           descramble_en = 1'b1;
   logic           lfsr_reload = 1'b0;
   logic [L*24-1:0] seed = {24'h0ABCDE, 24'h012345, 24'h000001, 24'h1DBFBC};
   logic [L-1:0]   in_valid = '0, in_dk = '0, in_block_start = '0;
   logic [L*8-1:0] in_data = '0;
   logic [L*2-1:0] in_sync_header = '0;
   logic [L-1:0]   out_valid, out_dk;
   logic [L*8-1:0] out_data;
   logic [22:0]    m3;
   logic           gen3_prev = 1'b0;
   int             total = 0, bad = 0;

   always #5 clk = ~clk;

   descrambler_multilane #(.LANES(L)) dut (
      .RX_CLK(clk), .rst(rst_n), .gen3_mode(gen3_mode), .descramble_en(descramble_en),
      .lfsr_reload(lfsr_reload), .seed(seed), .in_valid(in_valid), .in_data(in_data),
      .in_dk(in_dk), .in_sync_header(in_sync_header), .in_block_start(in_block_start),
      .out_valid(out_valid), .out_data(out_data), .out_dk(out_dk)
   );

   // Mode changes are only defined together with a reload (or while in reset)
   always @(posedge clk) begin
      if (rst_n) assert (gen3_mode === gen3_prev || lfsr_reload) else $error("gen3_mode changed without lfsr_reload");
      gen3_prev <= gen3_mode;
   end

   function automatic logic [7:0] od(input int l);
      return out_data[l*8 +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = '0;
      in_dk = '0;
      in_block_start = '0;
      lfsr_reload = 1'b0;
   endtask

   task automatic put(input int l, input logic [7:0] d, input logic k = 1'b0,
                      input logic bs = 1'b0, input logic [1:0] h = 2'b01);
      in_valid[l] = 1'b1;
      in_data[l*8 +: 8] = d;
      in_dk[l] = k;
      in_block_start[l] = bs;
      in_sync_header[l*2 +: 2] = h;
   endtask

   task automatic do_reset(input logic g3);
      idle();
      gen3_mode = g3;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   // Reference Gen3 scrambler: x^23+x^21+x^16+x^8+x^5+x^2+1, MSB-out, LSB-first
   task automatic scr3(input logic [7:0] p, output logic [7:0] s);
      logic fb;
      for (int b = 0; b < 8; b++) begin
         fb = m3[22];
         s[b] = p[b] ^ fb;
         m3 = {m3[21:0], fb};
         m3[2] ^= fb;
         m3[5] ^= fb;
         m3[8] ^= fb;
         m3[16] ^= fb;
         m3[21] ^= fb;
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      total++; if (out_valid !== '0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
      total++; if (out_dk !== '0) begin bad++; $display("FAIL reset_dk got %b want 0", out_dk); end
      put(0, 8'h00);
      put(2, 8'h5A);
      tick();
      idle();
      total++; if (od(0) !== 8'hFF) begin bad++; $display("FAIL first_sym lane0 got %h want ff", od(0)); end
      total++; if (od(2) !== 8'hA5) begin bad++; $display("FAIL first_sym lane2 got %h want a5", od(2)); end
      total++; if (out_valid !== 4'b0101) begin bad++; $display("FAIL first_sym valid got %b want 0101", out_valid); end
   endtask

   // Columns: {descramble_en, lfsr_reload, valid, dk, data_in, expected_out}
   task automatic test_gen12();
      logic [19:0] tab [18];
      logic [19:0] t;
      tab = '{
         {1'b1, 1'b0, 1'b1, 1'b1, 8'hBC, 8'hBC}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF},
         {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h17},
         {1'b1, 1'b0, 1'b1, 1'b1, 8'hBC, 8'hBC}, {1'b1, 1'b0, 1'b1, 1'b1, 8'h1C, 8'h1C},
         {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF}, {1'b1, 1'b0, 1'b1, 1'b1, 8'hBC, 8'hBC},
         {1'b1, 1'b0, 1'b1, 1'b1, 8'h7C, 8'h7C}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h17},
         {1'b1, 1'b0, 1'b1, 1'b1, 8'hBC, 8'hBC}, {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00},
         {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h17}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 8'hF3},
         {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h17},
         {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h17}, {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF}
      };
      for (int i = 0; i < 18; i++) begin
         t = tab[i];
         idle();
         descramble_en = t[19];
         lfsr_reload = t[18];
         if (t[17]) put(0, t[15:8], t[16]);
         tick();
         total++; if (od(0) !== t[7:0]) begin bad++; $display("FAIL gen12 row%0d data got %h want %h", i, od(0), t[7:0]); end
         total++; if (out_valid !== {3'b000, t[17]}) begin bad++; $display("FAIL gen12 row%0d valid got %b want %b", i, out_valid, {3'b000, t[17]}); end
         total++; if (out_dk[0] !== t[16]) begin bad++; $display("FAIL gen12 row%0d dk got %b want %b", i, out_dk[0], t[16]); end
      end
      idle();
      descramble_en = 1'b1;
   endtask

   task automatic test_gen3_data();
      logic [7:0] p, s;
      do_reset(1'b1);
      m3 = SEED0;
      for (int i = 0; i < 16; i++) begin
         p = 8'($urandom);
         scr3(p, s);
         idle();
         put(0, s, 1'b0, i == 0, 2'b01);
         tick();
         total++; if (od(0) !== p || out_valid[0] !== 1'b1) begin bad++; $display("FAIL gen3_data sym%0d got %h want %h", i, od(0), p); end
      end
      idle();
   endtask

   task automatic test_gen3_eieos();
      logic [7:0] p, s;
      for (int i = 0; i < 16; i++) begin
         idle();
         put(0, i == 0 ? 8'h00 : 8'hFF, 1'b0, i == 0, 2'b10);
         tick();
         total++; if (od(0) !== (i == 0 ? 8'h00 : 8'hFF)) begin bad++; $display("FAIL eieos_raw sym%0d got %h", i, od(0)); end
      end
      m3 = SEED0;
      for (int i = 0; i < 4; i++) begin
         p = 8'($urandom);
         scr3(p, s);
         idle();
         put(0, s, 1'b0, i == 0, 2'b01);
         tick();
         total++; if (od(0) !== p) begin bad++; $display("FAIL eieos_then_data sym%0d got %h want %h", i, od(0), p); end
      end
      scr3(8'h00, s);
      idle();
      put(0, 8'h2D, 1'b0, 1'b1, 2'b10);
      tick();
      total++; if (od(0) !== 8'h2D) begin bad++; $display("FAIL os_sym0 got %h want 2d", od(0)); end
      p = 8'h6B;
      scr3(p, s);
      idle();
      put(0, s);
      tick();
      total++; if (od(0) !== p) begin bad++; $display("FAIL os_sym1 got %h want %h", od(0), p); end
      idle();
   endtask

   task automatic test_gen3_skp();
      logic [7:0] p, s;
      idle();
      lfsr_reload = 1'b1;
      tick();
      m3 = SEED0;
      for (int i = 0; i < 20; i++) begin
         idle();
         if (i >= 6 && i < 14) begin
            put(0, 8'hAA, 1'b0, i == 6, 2'b10);
            p = 8'hAA;
         end else begin
            p = 8'($urandom);
            scr3(p, s);
            put(0, s, 1'b0, i == 0 || i == 14, 2'b01);
         end
         tick();
         total++; if (od(0) !== p) begin bad++; $display("FAIL skp_stream sym%0d got %h want %h", i, od(0), p); end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [7:0] p, s;
      m3 = SEED0;
      for (int i = 0; i < 3; i++) begin
         scr3(8'h11, s);
         idle();
         put(0, s, 1'b0, i == 0, 2'b01);
         tick();
      end
      #3 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== '0 || out_data !== '0 || out_dk !== '0) begin bad++; $display("FAIL async_reset got v=%b d=%h k=%b want 0", out_valid, out_data, out_dk); end
      tick();
      total++; if (out_valid !== '0 || out_data !== '0) begin bad++; $display("FAIL held_reset got v=%b d=%h want 0", out_valid, out_data); end
      rst_n = 1'b1;
      m3 = SEED0;
      p = 8'h3C;
      scr3(p, s);
      idle();
      put(0, s, 1'b0, 1'b1, 2'b01);
      tick();
      total++; if (od(0) !== p) begin bad++; $display("FAIL post_reset got %h want %h", od(0), p); end
      m3 = SEED0;
      p = 8'hC3;
      scr3(p, s);
      idle();
      lfsr_reload = 1'b1;
      put(0, s, 1'b0, 1'b1, 2'b01);
      tick();
      total++; if (od(0) !== p) begin bad++; $display("FAIL reload_sym got %h want %h", od(0), p); end
      p = 8'h5E;
      scr3(p, s);
      idle();
      put(0, s);
      tick();
      total++; if (od(0) !== p) begin bad++; $display("FAIL after_reload got %h want %h", od(0), p); end
      idle();
   endtask

   initial begin
      test_reset();
      test_gen12();
      test_gen3_data();
      test_gen3_eieos();
      test_gen3_skp();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
